// File: rtl/mul_pkg.sv
// mul_pkg: state encoding and helpers shared by the sequential multipliers.
//   state_t   : FSM encoding (ST_IDLE, ST_BUSY, ST_DONE)
//   abs_twos  : magnitude of a w-bit two's complement value, returned as w-bit unsigned
//               (zero-extended in a 64-bit container, so operands up to 64 bits).
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The most-negative value maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [63:0] abs_twos(input logic [63:0] x, input int unsigned w);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    r    = x & mask;
    if (((r >> (w - 1)) & 64'd1) != 64'd0) begin
      r = (~r + 64'd1) & mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// mul_shift_add_dp: datapath of the iterative shift-add multiplier.
//   clk, rst_n   : clock, synchronous active-low reset (clears z only)
//   load         : capture operand magnitudes and sign, clear the step counter
//   step         : perform one multiplier-bit iteration
//   a, b         : operands (WIDTH bits)
//   signed_mode  : 1 = two's complement operands, 0 = unsigned
//   last         : the current step is the final one
//   z            : product, loaded with the sign-corrected result on the final step
module mul_shift_add_dp
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               last,
  output logic [2*WIDTH-1:0] z
);

  localparam int CW = $clog2(WIDTH + 1);

  // acc = {acc_hi (WIDTH+1 bits, carry on top), acc_lo (WIDTH bits)}.
  // acc_lo starts as the multiplier magnitude and shifts out one bit per step
  // while product bits shift in from acc_hi.
  logic [WIDTH-1:0]   mag_a;
  logic [2*WIDTH:0]   acc;
  logic               neg;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] z_fix;

  always_comb begin
    mag_a_in = signed_mode ? WIDTH'(abs_twos(64'(a), WIDTH)) : a;
    mag_b_in = signed_mode ? WIDTH'(abs_twos(64'(b), WIDTH)) : b;
    // acc_hi's top bit is always 0 here (it was shifted down last step),
    // so this WIDTH+1-bit add cannot overflow.
    sum      = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mag_a}) : acc[2*WIDTH:WIDTH];
    acc_next = {sum, acc[WIDTH-1:0]} >> 1;
    prod     = acc_next[2*WIDTH-1:0];
    // Negating a zero product yields zero, so no negative-zero special case.
    z_fix    = neg ? (~prod + (2*WIDTH)'(1)) : prod;
    last     = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (load) begin
      mag_a <= mag_a_in;
      acc   <= {{(WIDTH + 1){1'b0}}, mag_b_in};
      neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      count <= '0;
    end else if (step) begin
      acc   <= acc_next;
      count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z <= '0;
    end else if (step && last) begin
      z <= z_fix;
    end
  end

endmodule

// File: rtl/mul_seq_shift_add.sv
// mul_seq_shift_add: iterative radix-2 shift-add multiplier, unsigned or signed per op.
//   clk, rst_n   : clock, synchronous active-low reset
//   in_valid     : a, b, signed_mode valid       in_ready  : idle, can accept an op
//   a, b         : WIDTH-bit operands            signed_mode: 1 = two's complement
//   out_valid    : z holds a finished product    out_ready : consumer takes z
//   z            : 2*WIDTH-bit product
// An op takes WIDTH BUSY cycles, then waits in DONE until out_ready.
module mul_seq_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z
);

  state_t state;
  state_t state_next;
  logic   load;
  logic   step;
  logic   last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step = 1'b1;
        if (last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .step        (step),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .last        (last),
    .z           (z)
  );

endmodule
